// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default field widths, the decode bubble,
// and the fetch packet passed from IF to ID.
package cpu_pkg;

  localparam int DEF_PC_W   = 32;
  localparam int DEF_INST_W = 32;

  // Values decode sees when nothing is queued (pc=0, instr=0).
  localparam int unsigned BUBBLE_PC    = 0;
  localparam int unsigned BUBBLE_INSTR = 0;

  typedef struct packed {
    logic [DEF_PC_W-1:0]   pc;
    logic [DEF_INST_W-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/if_id_queue_mem.sv
// Entry storage for the IF/ID queue: DEPTH x W registers with one synchronous
// write port and one asynchronous read port. Contents are not reset.
module if_id_queue_mem #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2,
  parameter int W      = 64
) (
  input  logic              clk_in,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// Instruction queue between IF and ID: ring buffer of (pc, instr) pairs with
// flush on branch redirect, a global rdy_in freeze, and a zero bubble when empty.
module if_id_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2,
  parameter int PC_W   = cpu_pkg::DEF_PC_W,
  parameter int INST_W = cpu_pkg::DEF_INST_W
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_instr,
  output logic [ADDR_W:0]   count_out
);

  localparam int W = PC_W + INST_W;
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              push;
  logic              pop;
  logic              mem_we;
  logic [W-1:0]      head;

  // Handshake: a transfer happens on a side exactly when valid & ready are both
  // high at the rising edge. Both readies/valids are gated by rdy_in, and
  // in_ready never depends on out_ready (no pop-through when full).
  assign in_ready  = rdy_in & (count != CNT_FULL);
  assign out_valid = rdy_in & (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count_out = count;

  // A flush (or reset) discards a same-cycle push, so the write is suppressed too.
  assign mem_we = push & ~flush_in & ~rst_in;

  if_id_queue_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .W      (W)
  ) u_mem (
    .clk_in (clk_in),
    .we     (mem_we),
    .waddr  (wr_ptr),
    .wdata  ({in_pc, in_instr}),
    .raddr  (rd_ptr),
    .rdata  (head)
  );

  assign out_pc    = out_valid ? head[W-1:INST_W]   : PC_W'(BUBBLE_PC);
  assign out_instr = out_valid ? head[INST_W-1:0]   : INST_W'(BUBBLE_INSTR);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        case ({push, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios followed by random traffic, all
// checked every cycle against a queue-based reference model.
module tb_if_id_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;
  localparam int PC_W   = 32;
  localparam int INST_W = 32;
  localparam int PW     = PC_W + INST_W;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              rdy_in;
  logic              flush_in;
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [INST_W-1:0] in_instr;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_instr;
  logic [ADDR_W:0]   count_out;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  logic [PW-1:0] exp_q[$];

  if_id_queue #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .PC_W   (PC_W),
    .INST_W (INST_W)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .flush_in  (flush_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .count_out (count_out)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model outputs derived from the queue contents and rdy_in.
  task automatic check_outputs();
    logic exp_ov;
    logic exp_ir;
    logic [PC_W-1:0]   exp_pc;
    logic [INST_W-1:0] exp_in;
    logic [ADDR_W-1:0] diff;
    exp_ov = rdy_in && (exp_q.size() > 0);
    exp_ir = rdy_in && (exp_q.size() < DEPTH);
    exp_pc = exp_ov ? exp_q[0][PW-1:INST_W] : '0;
    exp_in = exp_ov ? exp_q[0][INST_W-1:0]  : '0;
    chk("in_ready",  64'(in_ready),  64'(exp_ir));
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    chk("out_pc",    64'(out_pc),    64'(exp_pc));
    chk("out_instr", 64'(out_instr), 64'(exp_in));
    chk("count_out", 64'(count_out), 64'(exp_q.size()));
    diff = dut.wr_ptr - dut.rd_ptr;
    chk("ptr_invariant", 64'(count_out[ADDR_W-1:0]), 64'(diff));
  endtask

  task automatic model_update();
    bit do_push;
    bit do_pop;
    if (rst_in) begin
      exp_q.delete();
    end else if (rdy_in) begin
      if (flush_in) begin
        exp_q.delete();
      end else begin
        do_push = in_valid && (exp_q.size() < DEPTH);
        do_pop  = out_ready && (exp_q.size() > 0);
        if (do_pop)  void'(exp_q.pop_front());
        if (do_push) exp_q.push_back({in_pc, in_instr});
      end
    end
  endtask

  // One clock: check settled outputs, let the edge happen, advance the model.
  task automatic step();
    #1;
    if (chk_en) check_outputs();
    @(posedge clk_in);
    model_update();
    if (rst_in) chk_en = 1'b1;
    @(negedge clk_in);
  endtask

  // driver tasks
  task automatic idle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush_in  = 1'b0;
    rdy_in    = 1'b1;
    rst_in    = 1'b0;
  endtask

  task automatic push_one(input logic [PC_W-1:0] pc, input logic [INST_W-1:0] ins);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = ins;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      if (exp_q.size() > 0) step();
    end
    out_ready = 1'b0;
  endtask

  logic [INST_W-1:0] fill_ins [4];

  initial begin
    fill_ins[0] = 32'h0000_0013;
    fill_ins[1] = 32'h0010_0093;
    fill_ins[2] = 32'h0020_0113;
    fill_ins[3] = 32'h0030_0193;
    idle();
    in_pc    = '0;
    in_instr = '0;
    rst_in   = 1'b1;
    @(negedge clk_in);

    // Reset and fill
    step();
    step();
    rst_in = 1'b0;
    #1;
    chk("reset_count", 64'(count_out), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_pc", 64'(out_pc), 64'd0);
    for (int k = 0; k < 4; k++) push_one(32'h1000 + 32'(4 * k), fill_ins[k]);
    #1;
    chk("full_count", 64'(count_out), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_head_pc", 64'(out_pc), 64'h1000);
    chk("full_head_instr", 64'(out_instr), 64'h0000_0013);

    // Drain in order
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("drain_pc", 64'(out_pc), 64'(32'h1000 + 32'(4 * k)));
      step();
    end
    out_ready = 1'b0;
    #1;
    chk("empty_valid", 64'(out_valid), 64'd0);
    chk("empty_pc", 64'(out_pc), 64'd0);
    chk("empty_instr", 64'(out_instr), 64'd0);

    // Simultaneous push/pop with pointer wrap
    push_one(32'h2000, 32'h0);
    push_one(32'h2004, 32'h1);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_pc    = 32'h2008 + 32'(4 * k);
      in_instr = $urandom;
      #1;
      chk("pp_count", 64'(count_out), 64'd2);
      chk("pp_pc", 64'(out_pc), 64'(32'h2000 + 32'(4 * k)));
      step();
    end
    drain();

    // Flush priority over push and pop
    for (int k = 0; k < 3; k++) push_one(32'h2500 + 32'(4 * k), $urandom);
    flush_in  = 1'b1;
    in_valid  = 1'b1;
    in_pc     = 32'h3000;
    out_ready = 1'b1;
    step();
    idle();
    #1;
    chk("flush_count", 64'(count_out), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_pc", 64'(out_pc), 64'd0);

    // rdy_in freeze
    push_one(32'h5000, 32'h11);
    push_one(32'h5004, 32'h22);
    rdy_in    = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h5008;
    out_ready = 1'b1;
    flush_in  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("frz_in_ready", 64'(in_ready), 64'd0);
      chk("frz_valid", 64'(out_valid), 64'd0);
      chk("frz_count", 64'(count_out), 64'd2);
      step();
    end
    idle();
    #1;
    chk("frz_head_pc", 64'(out_pc), 64'h5000);
    drain();

    // Reset mid-operation
    for (int k = 0; k < 3; k++) push_one(32'h6000 + 32'(4 * k), $urandom);
    rst_in   = 1'b1;
    in_valid = 1'b1;
    in_pc    = 32'h6100;
    step();
    idle();
    #1;
    chk("mid_rst_count", 64'(count_out), 64'd0);
    chk("mid_rst_pc", 64'(out_pc), 64'd0);
    push_one(32'h4000, 32'h0);
    #1;
    chk("post_rst_pc", 64'(out_pc), 64'h4000);
    chk("post_rst_instr", 64'(out_instr), 64'h0);
    drain();

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush_in  = ($urandom_range(0, 19) == 0);
      rdy_in    = ($urandom_range(0, 9) != 0);
      rst_in    = ($urandom_range(0, 99) == 0);
      in_pc     = $urandom;
      in_instr  = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
      step();
    end
    idle();
    step();

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised instruction queue between the IF stage and the ID stage; successor of the single-entry IF/ID latch.
- Buffers up to DEPTH (pc, instruction) pairs, using valid/ready handshakes on both sides.
- Supports whole-queue flush on branch redirect and a global rdy_in freeze.
- Decode sees a zero bubble (pc=0, instr=0) whenever the queue is empty.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- ADDR_W, 2, log2(DEPTH); width of the read and write pointers.
- PC_W, 32, width of the pc field.
- INST_W, 32, width of the instruction field.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  reset: synchronous, active-high.
- rdy_in  input  1  global enable; when 0, all state is frozen.
- flush_in  input  1  branch redirect from EX; discards all entries.
- in_valid  input  1  IF presents a fetched pair.
- in_ready  output  1  queue accepts the pair this cycle.
- in_pc  input  PC_W  pc of the fetched instruction.
- in_instr  input  INST_W  fetched instruction word.
- out_valid  output  1  head entry is valid for ID.
- out_ready  input  1  ID consumes the head this cycle (stall = 0).
- out_pc  output  PC_W  head pc; 0 when out_valid=0.
- out_instr  output  INST_W  head instruction; 0 when out_valid=0.
- count_out  output  ADDR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage is a ring buffer mem[DEPTH] of {pc, instr}, with wr_ptr and rd_ptr (ADDR_W bits, wrap modulo DEPTH) and count (ADDR_W+1 bits).
- Reset (rst_in=1 at a clock edge): wr_ptr=rd_ptr=count=0. Reset has priority over flush_in and rdy_in.
  - Post-reset outputs: in_ready=1 if rdy_in=1, out_valid=0, out_pc=0, out_instr=0, count_out=0.
  - Reset mid-operation drops every entry; mem contents need not be cleared.
- Combinational outputs:
  - in_ready = rdy_in & (count != DEPTH). There is no pop-through when full, so in_ready has no path from out_ready.
  - out_valid = rdy_in & (count != 0).
  - out_pc/out_instr = mem[rd_ptr] when out_valid, otherwise 0.
  - count_out = count.
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Clock edge, rdy_in=0: nothing changes, even if flush_in=1 (matches the global pause semantics).
- Clock edge, rdy_in=1, flush_in=1:
  - wr_ptr=rd_ptr=count=0.
  - Any push or pop in the same cycle is discarded; the flush wins.
  - Next cycle: out_valid=0.
- Clock edge, rdy_in=1, flush_in=0:
  - push only: mem[wr_ptr]<={in_pc, in_instr}, wr_ptr+1, count+1.
  - pop only: rd_ptr+1, count-1.
  - push and pop together: both pointers advance and count is unchanged. This is legal at any count from 1 to DEPTH-1.
- Latency: an entry pushed at edge N is visible on out_* after edge N; earliest consumption is at edge N+1. There is no same-cycle bypass.
- Ordering: strict FIFO. Pointer wrap from DEPTH-1 to 0 must be seamless.
- Full (count=DEPTH): in_ready=0; IF must hold in_pc/in_instr.
- Empty (count=0): out_valid=0 and the bubble (0, 0) is presented.
- An in_instr of 0 is stored like any other value; it is not treated as "no instruction".
- Occupancy invariant: count never exceeds DEPTH or underflows. Bench assertion: count == (wr_ptr - rd_ptr) mod DEPTH, or DEPTH when full.

Decomposition:
- Shared package cpu_pkg:
  - PC_W and INST_W defaults.
  - BUBBLE_PC = 0 and BUBBLE_INSTR = 0.
  - Typedef fetch_pkt_t = {pc, instr}, reused by IF and ID.
- One sub-module is natural: if_id_queue_mem, the DEPTH x (PC_W+INST_W) register array with one write port and one asynchronous read port.
- Pointer, count, flush and handshake logic stay in if_id_queue.

Test Plan:
- Reset and fill: reset 2 cycles, then push pc 0x1000/0x1004/0x1008/0x100C with instrs 0x00000013, 0x00100093, 0x00200113, 0x00300193, and out_ready=0 → count_out=4, in_ready=0, out_pc=0x1000, out_instr=0x00000013.
- Drain in order: from full, hold out_ready=1 for 4 cycles → out_pc goes 0x1000, 0x1004, 0x1008, 0x100C, then out_valid=0 with out_pc=0 and out_instr=0.
- Simultaneous push/pop plus wrap: run 10 cycles with count=2 and push+pop every cycle (pcs 0x2000+4k) → count_out stays 2, outputs appear in order, and pointers wrap past 3 without loss.
- Flush priority: count=3, with flush_in=1, in_valid=1 (pc 0x3000) and out_ready=1 in the same cycle → next cycle count_out=0, out_valid=0, and pc 0x3000 is never emitted.
- rdy_in freeze: count=2, then rdy_in=0 for 3 cycles with in_valid=1, out_ready=1 and flush_in=1 → in_ready=0, out_valid=0, count_out=2. After rdy_in returns to 1, the same head pc is presented.
- Reset mid-operation: count=3, assert rst_in with in_valid=1 → next cycle count_out=0, out_pc=0; the first post-reset push (pc 0x4000) appears at the head.
